// File: rtl/mul5_sched_if.sv
// Handshake bundle for the x5 scheduler: requesters, engine and response.
// slave is the scheduler side, master the surrounding system.
interface mul5_sched_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req_vld;
  logic [NREQ-1:0]    req_rdy;
  logic [NREQ*DW-1:0] req_data;
  logic [DW-1:0]      eng_din;
  logic               eng_din_enb;
  logic [DW-1:0]      eng_dout;
  logic               eng_dout_enb;
  logic               rsp_vld;
  logic               rsp_rdy;
  logic [IW-1:0]      rsp_id;
  logic [DW-1:0]      rsp_data;
  logic [1:0]         rsp_err;
  logic               stray_err;

  modport slave (
    input  req_vld, req_data, eng_dout, eng_dout_enb, rsp_rdy,
    output req_rdy, eng_din, eng_din_enb,
    output rsp_vld, rsp_id, rsp_data, rsp_err, stray_err
  );

  modport master (
    output req_vld, req_data, eng_dout, eng_dout_enb, rsp_rdy,
    input  req_rdy, eng_din, eng_din_enb,
    input  rsp_vld, rsp_id, rsp_data, rsp_err, stray_err
  );
endinterface

// File: rtl/mul5_sched.sv
// Round-robin scheduler in front of a shared x5 engine.
// One transaction in flight; the result is checked and may time out.
module mul5_sched #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 30
) (
  input  logic         clk,
  input  logic         rst,
  mul5_sched_if.slave  bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] id_q;
  logic [DW-1:0] op_q;
  logic [CW-1:0] cnt;
  logic [IW-1:0] gnt_id;
  logic [IW-1:0] idx;
  logic          gnt_any;
  logic [NREQ-1:0] gnt_oh;
  logic [DW-1:0] golden;

  // first valid requester at or after ptr, wrapping
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_any && bus.req_vld[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
      idx = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
    end
    gnt_oh         = '0;
    gnt_oh[gnt_id] = gnt_any;
  end

  assign bus.req_rdy = (state == IDLE && !rst) ? gnt_oh : '0;
  assign bus.eng_din = op_q;
  assign golden      = op_q * DW'(5);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      ptr             <= '0;
      id_q            <= '0;
      op_q            <= '0;
      cnt             <= '0;
      bus.eng_din_enb <= 1'b0;
      bus.rsp_vld     <= 1'b0;
      bus.rsp_id      <= '0;
      bus.rsp_data    <= '0;
      bus.rsp_err     <= 2'b00;
      bus.stray_err   <= 1'b0;
    end else begin
      bus.eng_din_enb <= 1'b0;
      if (bus.eng_dout_enb && state != WAIT)
        bus.stray_err <= 1'b1;
      unique case (state)
        IDLE: begin
          if (gnt_any) begin
            op_q  <= bus.req_data[int'(gnt_id)*DW +: DW];
            id_q  <= gnt_id;
            ptr   <= (gnt_id == IW'(NREQ - 1)) ? '0
                     : gnt_id + 1'b1;
            bus.eng_din_enb <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= CW'(1);
          state <= WAIT;
        end
        WAIT: begin
          if (bus.eng_dout_enb) begin
            bus.rsp_vld  <= 1'b1;
            bus.rsp_id   <= id_q;
            bus.rsp_data <= bus.eng_dout;
            bus.rsp_err  <= (bus.eng_dout == golden)
                            ? 2'b00 : 2'b01;
            state        <= RESP;
          end else if (cnt == CW'(TIMEOUT)) begin
            bus.rsp_vld  <= 1'b1;
            bus.rsp_id   <= id_q;
            bus.rsp_data <= '0;
            bus.rsp_err  <= 2'b10;
            state        <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_rdy) begin
            bus.rsp_vld <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul5_sched.sv
// Directed bench for mul5_sched with a transaction-level reference
// model compared against the outputs on every falling edge.
module tb_mul5_sched;
  localparam int NREQ    = 4;
  localparam int DW      = 8;
  localparam int TIMEOUT = 30;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mul5_sched_if #(.NREQ(NREQ), .DW(DW)) bus ();

  mul5_sched #(
    .NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int passed = 0;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h at %0t",
                  name, act, exp, $time);
  endfunction

  function automatic int pick(logic [NREQ-1:0] v, int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  // Model: m_age counts cycles since the grant edge; 1 is the issue
  // cycle, age a >= 2 is waiting with the engine a-1 cycles old.
  logic       m_busy = 0, m_rsp = 0, m_stray = 0;
  int         m_age = 0, m_id = 0, m_ptr = 0, m_rsp_id = 0;
  logic [7:0] m_op = 0, m_rsp_data = 0;
  logic [1:0] m_rsp_err = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_rsp <= 0; m_stray <= 0; m_age <= 0;
      m_id <= 0; m_ptr <= 0; m_op <= 0;
      m_rsp_id <= 0; m_rsp_data <= 0; m_rsp_err <= 0;
    end else if (m_rsp) begin
      if (bus.eng_dout_enb) m_stray <= 1;
      if (bus.rsp_rdy) m_rsp <= 0;
    end else if (m_busy) begin
      if (m_age == 1) begin
        if (bus.eng_dout_enb) m_stray <= 1;
        m_age <= 2;
      end else if (bus.eng_dout_enb) begin
        m_busy <= 0; m_rsp <= 1; m_rsp_id <= m_id;
        m_rsp_data <= bus.eng_dout;
        m_rsp_err <= (bus.eng_dout == 8'(m_op * 5)) ? 2'd0 : 2'd1;
      end else if (m_age - 1 == TIMEOUT) begin
        m_busy <= 0; m_rsp <= 1; m_rsp_id <= m_id;
        m_rsp_data <= 0; m_rsp_err <= 2'd2;
      end else begin
        m_age <= m_age + 1;
      end
    end else begin
      if (bus.eng_dout_enb) m_stray <= 1;
      if (bus.req_vld != 0) begin
        m_busy <= 1; m_age <= 1;
        m_id  <= pick(bus.req_vld, m_ptr);
        m_op  <= bus.req_data[pick(bus.req_vld, m_ptr)*DW +: DW];
        m_ptr <= (pick(bus.req_vld, m_ptr) + 1) % NREQ;
      end
    end
  end

  int rdy0_cnt = 0;
  always @(negedge clk) begin
    if (bus.req_rdy[0]) rdy0_cnt <= rdy0_cnt + 1;
    chk("req_rdy", bus.req_rdy,
        (!rst && !m_busy && !m_rsp && bus.req_vld != 0)
        ? (4'b1 << pick(bus.req_vld, m_ptr)) : 4'b0);
    chk("eng_din_enb", bus.eng_din_enb, m_busy && m_age == 1);
    chk("eng_din", bus.eng_din, m_op);
    chk("rsp_vld", bus.rsp_vld, m_rsp);
    chk("rsp_id", bus.rsp_id, m_rsp_id);
    chk("rsp_data", bus.rsp_data, m_rsp_data);
    chk("rsp_err", bus.rsp_err, m_rsp_err);
    chk("stray_err", bus.stray_err, m_stray);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_issue(input bit clr);
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.eng_din_enb) ok = 1;
    end
    chk("issue_seen", ok, 1);
    tick();
    if (clr) bus.req_vld = '0;
  endtask

  task automatic reply(input int lat, input logic [7:0] v);
    repeat (lat - 1) tick();
    bus.eng_dout     = v;
    bus.eng_dout_enb = 1;
    tick();
    bus.eng_dout_enb = 0;
  endtask

  task automatic get_rsp(output int id, output int data,
                         output int err);
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (bus.rsp_vld) ok = 1;
    end
    chk("rsp_seen", ok, 1);
    id   = int'(bus.rsp_id);
    data = int'(bus.rsp_data);
    err  = int'(bus.rsp_err);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  int id, data, err, base, n, en_cnt, rdy_cnt, unstable;
  bit found;

  initial begin
    bus.req_vld = '0; bus.req_data = '0; bus.eng_dout = '0;
    bus.eng_dout_enb = 0; bus.rsp_rdy = 1;
    #1 rst = 1;
    tick(); tick();
    chk("reset_rsp_vld", bus.rsp_vld, 0);
    chk("reset_eng_din", bus.eng_din, 0);
    rst = 0;
    tick();

    // 7 -> 35, engine answers three cycles after the pulse
    base = rdy0_cnt;
    bus.req_data[7:0] = 8'd7;
    bus.req_vld = 4'b0001;
    wait_issue(1);
    reply(3, 8'd35);
    get_rsp(id, data, err);
    chk("s1_id", id, 0);
    chk("s1_data", data, 35);
    chk("s1_err", err, 0);
    chk("s1_rdy0_pulses", rdy0_cnt - base, 1);

    // 60*5 wraps to 44; 45 is a mismatch
    bus.req_data[7:0] = 8'd60;
    bus.req_vld = 4'b0001;
    wait_issue(1);
    reply(2, 8'd44);
    get_rsp(id, data, err);
    chk("s2_ok_err", err, 0);
    chk("s2_ok_data", data, 44);
    bus.req_vld = 4'b0001;
    wait_issue(1);
    reply(2, 8'd45);
    get_rsp(id, data, err);
    chk("s2_bad_err", err, 1);
    chk("s2_bad_data", data, 45);

    // all requesters held: grants 0,1,2,3,0 after reset
    rst = 1; tick(); rst = 0;
    bus.req_data = {8'd40, 8'd30, 8'd20, 8'd10};
    bus.req_vld = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_issue(k == 4);
      reply(1, 8'(bus.eng_din * 5));
      get_rsp(id, data, err);
      chk("s3_id", id, k % 4);
      chk("s3_data", data, ((k % 4 + 1) * 50) % 256);
      chk("s3_err", err, 0);
    end

    // timeout, then a late reply
    bus.rsp_rdy = 0;
    bus.req_data[15:8] = 8'd3;
    bus.req_vld = 4'b0010;
    wait_issue(1);
    n = 0; found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      n++;
      if (bus.rsp_vld) found = 1;
    end
    chk("s4_timeout_cycles", n, 31);
    chk("s4_err", bus.rsp_err, 2);
    bus.eng_dout = 8'd15;
    bus.eng_dout_enb = 1;
    @(posedge clk); #1;
    bus.eng_dout_enb = 0;
    @(negedge clk);
    chk("s4_stray", bus.stray_err, 1);
    chk("s4_err_kept", bus.rsp_err, 2);
    chk("s4_data_kept", bus.rsp_data, 0);
    bus.rsp_rdy = 1;
    tick();

    // response back-pressure with a new request waiting
    bus.rsp_rdy = 0;
    bus.req_data[23:16] = 8'd9;
    bus.req_data[31:24] = 8'd11;
    bus.req_vld = 4'b0100;
    wait_issue(1);
    reply(3, 8'd45);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.rsp_vld) found = 1;
    end
    chk("s5_rsp_seen", found, 1);
    chk("s5_id", bus.rsp_id, 2);
    chk("s5_data", bus.rsp_data, 45);
    bus.req_vld = 4'b1000;
    en_cnt = 0; rdy_cnt = 0; unstable = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.eng_din_enb) en_cnt++;
      if (bus.req_rdy != 0) rdy_cnt++;
      if (!bus.rsp_vld || bus.rsp_data != 8'd45 ||
          bus.rsp_id != 2'd2 || bus.rsp_err != 2'd0) unstable++;
    end
    chk("s5_no_issue", en_cnt, 0);
    chk("s5_no_rdy", rdy_cnt, 0);
    chk("s5_stable", unstable, 0);
    bus.rsp_rdy = 1;
    @(negedge clk);
    chk("s5_next_grant", bus.req_rdy, 4'b1000);
    wait_issue(1);
    reply(2, 8'd55);
    get_rsp(id, data, err);
    chk("s5_r3_id", id, 3);
    chk("s5_r3_data", data, 55);

    // reset in WAIT with the pointer away from 0
    bus.req_data[7:0] = 8'd2;
    bus.req_vld = 4'b0001;
    wait_issue(1);
    reply(1, 8'd10);
    get_rsp(id, data, err);
    bus.req_data[15:8] = 8'd4;
    bus.req_vld = 4'b0010;
    wait_issue(1);
    tick();
    bus.req_vld = 4'b1111;
    #1 rst = 1;
    #1;
    chk("s6_rdy", bus.req_rdy, 0);
    chk("s6_enb", bus.eng_din_enb, 0);
    chk("s6_din", bus.eng_din, 0);
    chk("s6_vld", bus.rsp_vld, 0);
    chk("s6_rsp", {bus.rsp_id, bus.rsp_data, bus.rsp_err}, 0);
    chk("s6_stray_clr", bus.stray_err, 0);
    tick();
    rst = 0;
    bus.req_vld = '0;
    reply(1, 8'd20);
    @(negedge clk);
    chk("s6_stray_set", bus.stray_err, 1);
    bus.req_vld = 4'b1111;
    #1;
    chk("s6_grant0", bus.req_rdy, 4'b0001);
    wait_issue(1);
    reply(1, 8'(bus.eng_din * 5));
    get_rsp(id, data, err);
    chk("s6_id", id, 0);
    chk("s6_data", data, 10);
    chk("s6_err", err, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
